// File: rtl/wrr_arb_hs_if.sv
// wrr_arb_hs_if: request/grant handshake bundle between N requesters and the weighted arbiter.
// The master side drives requests and downstream ready; the arbiter takes the slave side.
interface wrr_arb_hs_if #(
    parameter int REQ_NUM  = 7,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = $clog2(REQ_NUM)
);
    logic [REQ_NUM-1:0]          req;
    logic [REQ_NUM-1:0]          req_last;
    logic [REQ_NUM*WEIGHT_W-1:0] weight;
    logic                        gnt_ready;
    logic                        grant_valid;
    logic [REQ_NUM-1:0]          grant;
    logic [ID_W-1:0]             grant_id;

    modport master (
        output req, req_last, weight, gnt_ready,
        input  grant_valid, grant, grant_id
    );

    modport slave (
        input  req, req_last, weight, gnt_ready,
        output grant_valid, grant, grant_id
    );
endinterface

// File: rtl/wrr_arb_hs.sv
// wrr_arb_hs: weighted round-robin arbiter; a holder may win up to weight consecutive packets,
// and the registered grant is held until the last beat of its packet is accepted.
module wrr_arb_hs #(
    parameter int REQ_NUM  = 7,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = $clog2(REQ_NUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    wrr_arb_hs_if.slave   bus
);
    typedef enum logic {IDLE, GRANT} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cred_q, cred_d;
    logic [ID_W-1:0]     rot_id, idx;
    logic                found;
    logic [WEIGHT_W-1:0] w_arr [REQ_NUM];
    logic [WEIGHT_W-1:0] w_sel;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_w
        assign w_arr[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(REQ_NUM-1);
            cred_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
        end
    end

    // Search starts one past the last holder and visits the holder itself last.
    always_comb begin
        idx    = ptr_q;
        rot_id = ptr_q;
        found  = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = (idx == ID_W'(REQ_NUM-1)) ? '0 : idx + 1'b1;
            if (!found && bus.req[idx]) begin
                rot_id = idx;
                found  = 1'b1;
            end
        end
    end

    assign w_sel = w_arr[rot_id];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cred_d  = cred_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = GRANT;
                if (bus.req[ptr_q] && cred_q != '0) begin
                    cred_d = cred_q - 1'b1;
                end else begin
                    ptr_d  = rot_id;
                    cred_d = (w_sel == '0) ? '0 : w_sel - 1'b1;
                end
            end
        end else if (bus.gnt_ready && bus.req[ptr_q] && bus.req_last[ptr_q]) begin
            state_d = IDLE;
        end
    end

    // The holder index is ptr_q, so the grant is decoded from it while in GRANT.
    always_comb begin
        bus.grant_valid = (state_q == GRANT);
        bus.grant       = (state_q == GRANT) ? REQ_NUM'(1) << ptr_q : '0;
        bus.grant_id    = (state_q == GRANT) ? ptr_q : '0;
    end
endmodule

// File: tb/tb_wrr_arb_hs.sv
// tb_wrr_arb_hs: directed vectors for the weighted round-robin arbiter at N=4,
// with protocol and grant-shape invariants checked every cycle.
module tb_wrr_arb_hs;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
    int wt_exp   [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int wz_exp   [6] = '{-1, 1, -1, 2, -1, 1};

    wrr_arb_hs_if #(.REQ_NUM(N), .WEIGHT_W(WW)) bus ();

    wrr_arb_hs #(.REQ_NUM(N), .WEIGHT_W(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!bus.grant_valid || bus.req[bus.grant_id])
                else $error("requester %0d dropped req mid-packet", bus.grant_id);
            assert ($onehot0(bus.grant)) else $error("grant not one-hot: %b", bus.grant);
            assert (bus.grant_valid == |bus.grant) else $error("grant_valid inconsistent with grant");
            assert (!bus.grant_valid || bus.grant[bus.grant_id]) else $error("grant_id disagrees with grant");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // id < 0 means no grant is expected.
    task automatic chk_gnt(input string tag, input int id);
        chk({tag, ".valid"}, 32'(bus.grant_valid), (id >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".grant"}, 32'(bus.grant), (id >= 0) ? 32'(1 << id) : 32'd0);
        if (id >= 0) chk({tag, ".id"}, 32'(bus.grant_id), 32'(id));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_last  = '0;
        bus.weight    = '0;
        bus.gnt_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_last  = '0;
        bus.weight    = '0;
        bus.gnt_ready = 1'b0;
        tick();
        chk_gnt("reset", -1);
        do_reset();
        chk_gnt("post_reset", -1);

        bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req       = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.gnt_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_gnt($sformatf("fair%0d", i), (i % 2 == 0) ? fair_exp[i/2] : -1);
        end

        do_reset();
        bus.weight    = {4'd1, 4'd1, 4'd1, 4'd3};
        bus.req       = 4'b0011;
        bus.req_last  = 4'b1111;
        bus.gnt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_gnt($sformatf("wt%0d", i), (i % 2 == 0) ? wt_exp[i/2] : -1);
        end

        do_reset();
        bus.weight    = {4'd1, 4'd0, 4'd1, 4'd1};
        bus.req       = 4'b0100;
        bus.req_last  = 4'b1111;
        bus.gnt_ready = 1'b1;
        tick();
        chk_gnt("wz_first", 2);
        bus.req = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_gnt($sformatf("wz%0d", i), wz_exp[i]);
        end

        do_reset();
        bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req       = 4'b0001;
        bus.req_last  = 4'b0000;
        bus.gnt_ready = 1'b1;
        tick();
        chk_gnt("mb_c1", 0);
        tick();
        chk_gnt("mb_c2", 0);
        bus.gnt_ready = 1'b0;
        tick();
        chk_gnt("mb_c3", 0);
        bus.gnt_ready = 1'b1;
        tick();
        chk_gnt("mb_c4", 0);
        bus.req_last = 4'b0001;
        tick();
        chk_gnt("mb_bubble", -1);
        tick();
        chk_gnt("mb_regrant", 0);

        do_reset();
        bus.weight    = {4'd1, 4'd1, 4'd1, 4'd4};
        bus.req       = 4'b1001;
        bus.req_last  = 4'b1111;
        bus.gnt_ready = 1'b1;
        tick();
        chk_gnt("drop_first", 0);
        tick();
        chk_gnt("drop_bubble", -1);
        bus.req = 4'b1000;
        tick();
        chk_gnt("drop_next", 3);

        do_reset();
        bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req       = 4'b0001;
        bus.req_last  = 4'b0000;
        bus.gnt_ready = 1'b0;
        tick();
        chk_gnt("rst_pre", 0);
        tick();
        chk_gnt("rst_stall", 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_gnt("rst_async", -1);
        bus.req       = 4'b1010;
        bus.req_last  = 4'b1111;
        bus.gnt_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk_gnt("rst_held", -1);
        tick();
        chk_gnt("rst_after", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wrr_arb_hs.md
Name: wrr_arb_hs

Overview:
- Parametrised weighted round-robin arbiter with a packet-level valid/ready grant handshake.
- Successor to the team's single-cycle round-robin arbiter. Each requester may win up to WEIGHT consecutive packets before priority rotates.
- The grant is registered and held across multi-beat packets until the last beat is accepted downstream.
- Sits in front of shared buses and ports where N masters contend for one multi-beat target.

Parameters:
- REQ_NUM, 7, number of requesters N (N >= 2).
- WEIGHT_W, 4, width of each per-requester weight field.
- ID_W, $clog2(REQ_NUM), width of grant_id.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  REQ_NUM  per-requester request; held high by the requester until its packet completes.
- req_last  input  REQ_NUM  per-requester last-beat flag; only meaningful for the granted index.
- weight  input  REQ_NUM*WEIGHT_W  packed weights; requester i uses bits [i*WEIGHT_W +: WEIGHT_W].
- gnt_ready  input  1  downstream accepts the current beat.
- grant_valid  output  1  a grant is active.
- grant  output  REQ_NUM  registered one-hot grant.
- grant_id  output  ID_W  binary index of the granted requester.

Behaviour:
- Reset values: grant_valid=0, grant=0, grant_id=0, state=IDLE, ptr=N-1, cred=0.
- State machine: IDLE and GRANT.
- Internal registers:
  - ptr (ID_W): index of the last holder.
  - cred (WEIGHT_W): extra packets the holder may still take.
- Effective weight: w_eff(i) = weight_i, with weight 0 treated as 1.
- IDLE, req==0: stay in IDLE; all outputs remain 0.
- IDLE, |req, winner selection in priority order:
  - Keep: if req[ptr] && cred!=0, winner=ptr and cred <= cred-1.
  - Rotate: otherwise winner = first set req at index ptr+1, ptr+2, ... wrapping modulo N, searching all N positions including ptr last. Then cred <= w_eff(winner)-1 and ptr <= winner.
- Latency: winner is registered into grant, grant_id and grant_valid=1 in the next cycle; state goes to GRANT. req first seen in IDLE at cycle t gives grant_valid at t+1.
- Weights are sampled only at the rotate decision. A weight change mid-burst does not affect the current cred.
- GRANT: accepted beat = gnt_ready & req[grant_id].
  - grant, grant_id and grant_valid are held constant regardless of other req bits.
  - Accepted beat with req_last[grant_id]=1 ends the packet: next cycle grant=0, grant_valid=0, state=IDLE.
  - Each packet therefore costs one IDLE bubble cycle; this is intended, not a bug.
- gnt_ready=0 stalls; the grant is held indefinitely, with no timeout.
- req[grant_id] dropping mid-packet: no beats are accepted and the grant is held. Requester protocol forbids this; the bench flags it with an assertion.
- Keep-rule boundaries:
  - Holder drops req at the decision point: cred is ignored and rotation proceeds from ptr+1.
  - Holder is the only requester with cred==0: it wins via rotation and cred is reloaded.
- First arbitration after reset: ptr=N-1 and cred=0, so the lowest set index wins.
- Reset asserted mid-packet: all outputs clear asynchronously; after release, behaviour is identical to power-on.
- Invariants:
  - grant is zero or one-hot.
  - grant_id always matches the grant bit whenever grant_valid=1.
  - grant_valid == |grant.

Test Plan:
- Fairness (N=4, all weights=1, req=4'b1111 constant, req_last=4'b1111, gnt_ready=1) -> grant_id sequence 0,1,2,3,0,1, one grant every 2 cycles, grant_valid toggling 1,0.
- Weighting (w0=3, w1=1, req=4'b0011, single-beat packets) -> grant_id 0,0,0,1,0,0,0,1.
- Weight zero (w2=0, req=4'b0100 then 4'b0110) -> requester 2 behaves as weight 1; after 2's packet the next grant is 1 via wrap (search 3,0,1).
- Multi-beat stall (req=4'b0001; gnt_ready 1,0,1,1; req_last on 3rd accepted beat) -> grant=4'b0001 held for 4 GRANT cycles, then grant=0 for exactly one cycle.
- Holder drop (w0=4, req0 drops after its 1st packet while req3=1) -> next grant_id=3 despite cred=3 remaining.
- Reset mid-packet (rst_n low during a beat, gnt_ready=0) -> grant/grant_valid go 0 with no clock edge; after release with req=4'b1010 the first grant_id=1.
